// File: rtl/ltl_symbol_feeder.sv
// ltl_symbol_feeder
//   Producer end of the monitor symbol interface. Classified trace events are
//   buffered in a small FIFO and issued to the monitor automata as one 8-bit
//   symbol per cycle ({1'b0, class, payload}), qualified by run_o. Before each
//   stream the automata are held in reset for RST_CYCLES cycles.
//
// Parameters
//   DEPTH       FIFO entries (power of two, >= 2)
//   RST_CYCLES  cycles monitor_reset_o is held in ARM (>= 1)
//
// Ports
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   start_i / stop_i         session start / stop-after-drain pulses
//   evt_valid_i/_class_i/_payload_i, evt_ready_o   event handshake
//   symbols_o, run_o         symbol and its valid qualifier (registered)
//   monitor_reset_o          active-high reset to the automata (registered)
//   busy_o                   state is not IDLE
//   drop_cnt_o, overflow_o   only when LTL_FEEDER_DROP_EN is defined
//
// Build option
//   LTL_FEEDER_DROP_EN  defined: events arriving while the FIFO is full are
//                       accepted and discarded, and counted.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | no session; automata held in reset
// ARM    | reset countdown to the automata before the stream starts
// STREAM | accepting events, issuing one symbol per cycle when available
// DRAIN  | no longer accepting; issuing what is left, then back to IDLE
module ltl_symbol_feeder #(
  parameter int DEPTH      = 8,
  parameter int RST_CYCLES = 2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic       stop_i,
  input  logic       evt_valid_i,
  input  logic [1:0] evt_class_i,
  input  logic [4:0] evt_payload_i,
  output logic       evt_ready_o,
  output logic [7:0] symbols_o,
  output logic       run_o,
  output logic       monitor_reset_o,
`ifdef LTL_FEEDER_DROP_EN
  output logic [15:0] drop_cnt_o,
  output logic        overflow_o,
`endif
  output logic       busy_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ARM    = 2'd1,
    S_STREAM = 2'd2,
    S_DRAIN  = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [6:0]    r_mem [DEPTH];
  logic [AW:0]   r_wptr;
  logic [AW:0]   r_rptr;
  logic [7:0]    r_sym;
  logic          r_run;
  logic          r_mrst;

  logic w_empty;
  logic w_full;
  logic w_push;
  logic w_pop;
  logic w_mrst_nxt;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

`ifdef LTL_FEEDER_DROP_EN
  logic [15:0] r_drop_cnt;
  logic        r_overflow;
  logic        w_drop;

  // Always ready in STREAM; the full check decides between store and discard.
  assign evt_ready_o = (r_state == S_STREAM);
  assign w_drop      = evt_valid_i && evt_ready_o && w_full;
  assign drop_cnt_o  = r_drop_cnt;
  assign overflow_o  = r_overflow;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_drop_cnt <= 16'h0000;
      r_overflow <= 1'b0;
    end else if (start_i) begin
      r_drop_cnt <= 16'h0000;
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      if (r_drop_cnt != 16'hFFFF) begin
        r_drop_cnt <= r_drop_cnt + 16'h0001;
      end
      r_overflow <= 1'b1;
    end
  end
`else
  assign evt_ready_o = (r_state == S_STREAM) && !w_full;
`endif

  assign w_push = evt_valid_i && evt_ready_o && !w_full;
  assign w_pop  = ((r_state == S_STREAM) || (r_state == S_DRAIN)) && !w_empty;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_state_nxt = S_ARM;
        end
      end
      S_ARM: begin
        if (stop_i) begin
          w_state_nxt = S_IDLE;
        end else if (r_cnt == '0) begin
          w_state_nxt = S_STREAM;
        end
      end
      S_STREAM: begin
        if (stop_i) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Empty here means the last pop has already been registered on symbols_o.
        if (w_empty) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // The automata run only while the next state is STREAM or DRAIN.
  assign w_mrst_nxt = !((w_state_nxt == S_STREAM) || (w_state_nxt == S_DRAIN));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else if ((r_state == S_IDLE) && start_i) begin
      r_cnt <= CW'(RST_CYCLES - 1);
    end else if ((r_state == S_ARM) && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wptr[AW-1:0]] <= {evt_class_i, evt_payload_i};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sym  <= 8'h00;
      r_run  <= 1'b0;
      r_mrst <= 1'b1;
    end else begin
      r_run  <= w_pop;
      r_mrst <= w_mrst_nxt;
      if (w_pop) begin
        r_sym <= {1'b0, r_mem[r_rptr[AW-1:0]]};
      end
    end
  end

  assign symbols_o       = r_sym;
  assign run_o           = r_run;
  assign monitor_reset_o = r_mrst;
  assign busy_o          = (r_state != S_IDLE);

endmodule

// File: tb/tb_ltl_symbol_feeder.sv
module tb_ltl_symbol_feeder;

  localparam int DEPTH      = 8;
  localparam int RST_CYCLES = 2;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       stop;
  logic       valid;
  logic [1:0] cls;
  logic [4:0] pay;
  logic       ready;
  logic [7:0] sym;
  logic       run;
  logic       mrst;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;

  ltl_symbol_feeder #(.DEPTH(DEPTH), .RST_CYCLES(RST_CYCLES)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .start_i        (start),
    .stop_i         (stop),
    .evt_valid_i    (valid),
    .evt_class_i    (cls),
    .evt_payload_i  (pay),
    .evt_ready_o    (ready),
    .symbols_o      (sym),
    .run_o          (run),
    .monitor_reset_o(mrst),
    .busy_o         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model. Session phase: 0 idle, 1 arming, 2 streaming, 3 draining.
  int         m_phase    = 0;
  int         m_arm_left = 0;
  logic [7:0] m_q[$];
  logic [7:0] m_sym      = 8'h00;
  logic       m_run      = 1'b0;
  logic       m_mrst     = 1'b1;
  int         m_sz;
  bit         m_take;
  bit         m_give;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0;
      m_q.delete();
      m_sym  = 8'h00;
      m_run  = 1'b0;
      m_mrst = 1'b1;
    end else begin
      m_sz   = m_q.size();
      m_take = (m_phase == 2) && valid && (m_sz < DEPTH);
      m_give = ((m_phase == 2) || (m_phase == 3)) && (m_sz > 0);
      if (m_give) begin
        m_sym = m_q.pop_front();
        m_run = 1'b1;
      end else begin
        m_run = 1'b0;
      end
      if (m_take) m_q.push_back({1'b0, cls, pay});
      case (m_phase)
        0: if (start) begin m_phase = 1; m_arm_left = RST_CYCLES; end
        1: begin
          if (stop) m_phase = 0;
          else begin
            m_arm_left--;
            if (m_arm_left == 0) m_phase = 2;
          end
        end
        2: if (stop) m_phase = 3;
        3: if (m_sz == 0) m_phase = 0;
        default: m_phase = 0;
      endcase
      m_mrst = !((m_phase == 2) || (m_phase == 3));
    end
  end

  always @(negedge clk) begin
    chk("symbols", sym, m_sym);
    chk("run", run, m_run);
    chk("monitor_reset", mrst, m_mrst);
    chk("evt_ready", ready, (m_phase == 2) && (m_q.size() < DEPTH));
    chk("busy", busy, m_phase != 0);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while (busy && k < 50) begin
      tick();
      k++;
    end
    chk(name, busy, 1'b0);
  endtask

  initial begin
    rst_n = 1'b1;
    start = 1'b0;
    stop  = 1'b0;
    valid = 1'b0;
    cls   = 2'd0;
    pay   = 5'd0;
    #2 rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_symbols", sym, 8'h00);
    chk("rst_run", run, 1'b0);
    chk("rst_mreset", mrst, 1'b1);
    chk("rst_ready", ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rst_n = 1'b1;

    // Arm sequence: reset held two cycles after start, low on the third.
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("arm_busy", busy, 1'b1);
    chk("arm_mreset1", mrst, 1'b1);
    tick();
    chk("arm_mreset2", mrst, 1'b1);
    tick();
    chk("arm_mreset3", mrst, 1'b0);
    chk("arm_ready", ready, 1'b1);

    // Two known events: class 2 / payload 5, then class 0 / payload 31.
    valid = 1'b1; cls = 2'd2; pay = 5'd5;
    tick();
    cls = 2'd0; pay = 5'd31;
    tick();
    valid = 1'b0;
    chk("lit_sym0", sym, 8'h45);
    chk("lit_run0", run, 1'b1);
    tick();
    chk("lit_sym1", sym, 8'h1F);
    chk("lit_run1", run, 1'b1);
    tick();
    chk("lit_run2", run, 1'b0);
    chk("lit_hold", sym, 8'h1F);

    // Back-to-back burst of nine events.
    for (int i = 0; i < 9; i++) begin
      valid = 1'b1;
      cls   = 2'($urandom);
      pay   = 5'($urandom);
      tick();
    end
    valid = 1'b0;
    repeat (4) tick();

    // Random traffic with occasional start/stop pulses.
    for (int i = 0; i < 600; i++) begin
      valid = ($urandom_range(0, 3) != 0);
      cls   = 2'($urandom);
      pay   = 5'($urandom);
      start = ($urandom_range(0, 39) == 0);
      stop  = ($urandom_range(0, 39) == 0);
      tick();
    end
    valid = 1'b0; start = 1'b0; stop = 1'b1;
    tick();
    stop = 1'b0;
    wait_idle("idle_after_random");

    // Stop while events are flowing; the event handshaked with stop is kept.
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (2) tick();
    for (int i = 0; i < 3; i++) begin
      valid = 1'b1; cls = 2'(i + 1); pay = 5'(i + 7);
      if (i == 2) stop = 1'b1;
      tick();
    end
    valid = 1'b0; stop = 1'b0;
    chk("drain_ready", ready, 1'b0);
    chk("drain_busy", busy, 1'b1);
    wait_idle("drain_to_idle");
    chk("drain_run", run, 1'b0);
    chk("drain_last_sym", sym, 8'h69);

    // Asynchronous reset in the middle of a stream.
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (2) tick();
    for (int i = 0; i < 4; i++) begin
      valid = 1'b1; cls = 2'd3; pay = 5'(i);
      tick();
    end
    #2 rst_n = 1'b0;
    #1;
    chk("arst_symbols", sym, 8'h00);
    chk("arst_run", run, 1'b0);
    chk("arst_mreset", mrst, 1'b1);
    chk("arst_ready", ready, 1'b0);
    chk("arst_busy", busy, 1'b0);
    valid = 1'b0;
    tick();
    #2 rst_n = 1'b1;
    repeat (10) tick();
    chk("arst_post_run", run, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
